// File: rtl/uart_pkg.sv
`default_nettype none
// ---- uart_pkg : state type and data width shared by the UART receiver and transmitter ----
// ---- Revision 1.0 ----
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ---- uart_rx_if : received-byte stream (data/valid/ready) between receiver and consumer ----
// ---- Revision 1.0 ----
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ---- uart_fifo : first-word-fall-through byte FIFO, depth BUFFER_SIZE (power of two) ----
// ---- Revision 1.0 ----
module uart_fifo
  import uart_pkg::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] push_data,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] pop_data,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(BUFFER_SIZE);

  logic [UART_DATA_BITS-1:0] mem [BUFFER_SIZE];
  logic [AW:0]               wp;
  logic [AW:0]               rp;
  logic                      do_push;
  logic                      do_pop;

  // One extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rp[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---- uart_rx : 8N1 serial receiver feeding a FWFT byte FIFO; macro UART_RX_SYNC_EN adds a 2-flop rx synchronizer ----
// ---- Revision 1.0 ----
module uart_rx
  import uart_pkg::*;
#(
  parameter int CDIV        = 10,
  parameter int BUFFER_SIZE = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun
);

  localparam int              CW        = $clog2(CDIV);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CDIV / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CDIV - 1);

  logic                      rx_s;
  logic                      prev_rx;
  uart_state_t               state;
  uart_state_t               state_nxt;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic [2:0]                bit_cnt;
  logic [2:0]                bit_cnt_nxt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] shreg_nxt;
  logic                      push;
  logic                      ferr_nxt;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  // Reset low so a line held low across reset release cannot look like a start edge.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      prev_rx   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      prev_rx   <= rx_s;
      frame_err <= ferr_nxt;
      overrun   <= push && fifo_full && !fifo_pop;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    push        = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (prev_rx && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_cnt == 3'd7) state_nxt   = STOP;
          else                 bit_cnt_nxt = bit_cnt + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE mid stop bit; a new start still needs a fresh falling edge.
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          push      = rx_s;
          ferr_nxt  = !rx_s;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_fifo #(
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop  = bus.ready && !fifo_empty;
  assign bus.valid = !fifo_empty;
  assign bus.data  = fifo_empty ? '0 : fifo_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---- tb_uart_rx : scoreboard bench for uart_rx (CDIV=10, BUFFER_SIZE=4) ----
// ---- Revision 1.0 ----
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CDIV  = 10;
  localparam int BUFSZ = 4;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 98;
`else
  localparam int LAT = 96;
`endif
  localparam int SD = LAT - 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err;
  logic overrun;

  uart_rx_if bus ();

  uart_rx #(
    .CDIV        (CDIV),
    .BUFFER_SIZE (BUFSZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q [$];
  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int fe0;
  int ov0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(CDIV);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      cycles(CDIV);
    end
    rx = stop;
    cycles(CDIV);
  endtask

  // Monitor: pops the scoreboard whenever the consumer handshake completes.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (!bus.valid) check("data_zero_when_empty", bus.data, 32'h0);
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=%0h required=none", bus.data);
        end else begin
          check("pop_data", bus.data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] b7e;
    logic [7:0] burst [5];
    b7e   = 8'h7E;
    burst = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    bus.ready = 1'b0;

    // Reset state
    cycles(3);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dut.state, IDLE);
    rst = 1'b0;
    cycles(3);

    // Single byte 'a' with latency check, then pop
    exp_q.push_back(8'h61);
    fork
      drive_frame(8'h61, 1'b1);
      begin
        cycles(LAT - 1);
        check("a_valid_before", bus.valid, 0);
        cycles(1);
        check("a_valid_rise", bus.valid, 1);
        check("a_data", bus.data, 32'h61);
        check("a_frame_err", frame_err, 0);
      end
    join
    bus.ready = 1'b1;
    cycles(1);
    bus.ready = 1'b0;
    check("a_popped_valid", bus.valid, 0);
    check("a_queue_empty", exp_q.size(), 0);

    // Three-cycle glitch is a false start
    fe0 = fe_cnt;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(2 + SD);
    check("glitch_state_start", dut.state, START);
    cycles(1);
    check("glitch_state_idle", dut.state, IDLE);
    cycles(150);
    check("glitch_valid", bus.valid, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // Bad stop bit then a held-low break
    fe0 = fe_cnt;
    fork
      drive_frame(8'h55, 1'b0);
      begin
        cycles(LAT - 1);
        check("ferr_before", frame_err, 0);
        cycles(1);
        check("ferr_pulse", frame_err, 1);
        cycles(1);
        check("ferr_one_cycle", frame_err, 0);
      end
    join
    cycles(200);
    check("break_ferr_count", fe_cnt - fe0, 1);
    check("break_valid", bus.valid, 0);
    rx = 1'b1;
    cycles(5);

    // Five back-to-back bytes with no consumer: the fifth overruns
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < BUFSZ) exp_q.push_back(burst[i]);
      drive_frame(burst[i], 1'b1);
    end
    check("burst_overrun_count", ov_cnt - ov0, 1);
    check("burst_head", bus.data, 32'h61);
    check("burst_full", dut.fifo_full, 1);

    // Full FIFO, pop on the stop-sample cycle: push accepted, no overrun
    exp_q.push_back(8'h66);
    fork
      drive_frame(8'h66, 1'b1);
      begin
        cycles(LAT - 1);
        bus.ready = 1'b1;
        cycles(1);
        bus.ready = 1'b0;
        check("pushpop_still_full", dut.fifo_full, 1);
      end
    join
    check("pushpop_no_overrun", ov_cnt - ov0, 1);
    bus.ready = 1'b1;
    cycles(8);
    bus.ready = 1'b0;
    check("drain_valid", bus.valid, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    // Reset mid-frame discards buffered data and the partial frame
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    check("pre_reset_valid", bus.valid, 1);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    cycles(CDIV);
    for (int k = 0; k < 3; k++) begin
      rx = b7e[k];
      cycles(CDIV);
    end
    rst = 1'b1;
    rx  = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    check("post_reset_valid", bus.valid, 0);
    cycles(20);
    check("post_reset_state", dut.state, IDLE);
    check("post_reset_valid_later", bus.valid, 0);
    check("post_reset_no_ferr", fe_cnt - fe0, 0);
    check("post_reset_no_ovr", ov_cnt - ov0, 0);

    // Clean frame after the aborted one
    exp_q.push_back(8'h7E);
    fork
      drive_frame(8'h7E, 1'b1);
      begin
        cycles(LAT - 1);
        check("7e_valid_before", bus.valid, 0);
        cycles(1);
        check("7e_valid_rise", bus.valid, 1);
        check("7e_data", bus.data, 32'h7E);
      end
    join
    bus.ready = 1'b1;
    cycles(1);
    bus.ready = 1'b0;
    cycles(2);
    check("7e_popped_valid", bus.valid, 0);
    check("7e_queue_empty", exp_q.size(), 0);
    check("final_no_ferr", fe_cnt - fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
